// File: rtl/inv_key_scheduler_pkg.sv
// Shared definitions for the AES-128 inverse key scheduler.
//   NR          : number of AES-128 rounds
//   state_e     : scheduler state encoding (idle, forward expansion, backward walk)
//   rcon()      : round constant word for round index 0..9, zero otherwise
//   rot_word()  : AES RotWord, top byte moved to the bottom
package inv_key_scheduler_pkg;

  localparam int unsigned NR = 10;

  typedef enum logic [1:0] {
    StIdle,
    StExpand,
    StReady
  } state_e;

  function automatic logic [31:0] rcon(input logic [3:0] idx);
    logic [7:0] b;
    case (idx)
      4'd0:    b = 8'h01;
      4'd1:    b = 8'h02;
      4'd2:    b = 8'h04;
      4'd3:    b = 8'h08;
      4'd4:    b = 8'h10;
      4'd5:    b = 8'h20;
      4'd6:    b = 8'h40;
      4'd7:    b = 8'h80;
      4'd8:    b = 8'h1b;
      4'd9:    b = 8'h36;
      default: b = 8'h00;
    endcase
    return {b, 24'h000000};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/inv_key_scheduler_sbox.sv
// AES forward S-box, purely combinational lookup.
//   din  : input byte
//   dout : substituted byte
module inv_key_scheduler_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  localparam logic [7:0] Sbox [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign dout = Sbox[din];

endmodule

// File: rtl/inv_key_scheduler_sub_word.sv
// AES SubWord: applies the S-box independently to each byte of a 32-bit word.
//   din  : input word
//   dout : substituted word, byte order preserved
module inv_key_scheduler_sub_word (
  input  logic [31:0] din,
  output logic [31:0] dout
);

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    inv_key_scheduler_sbox u_sbox (
      .din  (din[8*i +: 8]),
      .dout (dout[8*i +: 8])
    );
  end

endmodule

// File: rtl/inv_key_scheduler.sv
// AES-128 decryption-side key scheduler. A load captures the cipher key and
// expands it forward to round 10; afterwards each step request walks back one
// round key until round 0 (the original cipher key).
//   clk, rst  : clock, asynchronous active-high reset
//   load      : capture inkey and (re)start forward expansion; beats step
//   inkey     : cipher key, w0 = [127:96] .. w3 = [31:0]
//   step      : request previous round key (only in READY with round > 0)
//   busy      : forward expansion in progress
//   keyvalid  : outkey holds a valid round key
//   round     : round index of outkey
//   outkey    : key register contents, qualify with keyvalid
module inv_key_scheduler #(
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [127:0] inkey,
  input  logic         step,
  output logic         busy,
  output logic         keyvalid,
  output logic [3:0]   round,
  output logic [127:0] outkey
);

  import inv_key_scheduler_pkg::*;

  if (NR != inv_key_scheduler_pkg::NR) begin : g_nr_check
    $error("inv_key_scheduler supports only NR = 10 (AES-128)");
  end

  state_e       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   round_q, round_d;

  logic [31:0] k0, k1, k2, k3;
  logic [31:0] sw_in, sw_out;
  logic [31:0] t, n0, n1, n2, n3;
  logic [31:0] p0, p1, p2, p3;

  assign {k0, k1, k2, k3} = key_q;

  // One shared SubWord: forward uses w3, inverse needs the recovered previous w3 (k3^k2).
  assign sw_in = (state_q == StReady) ? rot_word(k3 ^ k2) : rot_word(k3);

  inv_key_scheduler_sub_word u_sub_word (
    .din  (sw_in),
    .dout (sw_out)
  );

  // Forward step r -> r+1
  assign t  = sw_out ^ rcon(round_q);
  assign n0 = k0 ^ t;
  assign n1 = n0 ^ k1;
  assign n2 = n1 ^ k2;
  assign n3 = n2 ^ k3;

  // Inverse step r -> r-1
  assign p3 = k3 ^ k2;
  assign p2 = k2 ^ k1;
  assign p1 = k1 ^ k0;
  assign p0 = k0 ^ sw_out ^ rcon(round_q - 4'd1);

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    if (load) begin
      state_d = StExpand;
      key_d   = inkey;
      round_d = 4'd0;
    end else begin
      unique case (state_q)
        StExpand: begin
          key_d   = {n0, n1, n2, n3};
          round_d = round_q + 4'd1;
          if (round_q == 4'(NR - 1)) begin
            state_d = StReady;
          end
        end
        StReady: begin
          if (step && (round_q != 4'd0)) begin
            key_d   = {p0, p1, p2, p3};
            round_d = round_q - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      key_q   <= '0;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
    end
  end

  assign busy     = (state_q == StExpand);
  assign keyvalid = (state_q == StReady);
  assign round    = round_q;
  assign outkey   = key_q;

endmodule

// File: tb/tb_inv_key_scheduler.sv
// Self-checking bench for inv_key_scheduler: a table-based AES-128 key-expansion
// model (S-box derived from GF(2^8) inversion) checked every cycle, plus
// FIPS-197 literal expectations.
module tb_inv_key_scheduler;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         load = 1'b0;
  logic [127:0] inkey = '0;
  logic         step = 1'b0;
  logic         busy, keyvalid;
  logic [3:0]   round;
  logic [127:0] outkey;

  int checks = 0;
  int errors = 0;
  logic cmp_en = 1'b0;

  inv_key_scheduler #(.NR(10)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .inkey    (inkey),
    .step     (step),
    .busy     (busy),
    .keyvalid (keyvalid),
    .round    (round),
    .outkey   (outkey)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [7:0]   m_sb [256];
  logic [127:0] m_rk [0:10];
  int           m_phase = 0;  // 0 idle, 1 expanding, 2 ready
  int           m_round = 0;
  bit           m_have = 1'b0;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d = {b, b};
    return d[15-n -: 8];
  endfunction

  task automatic build_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv = 8'h00;
      if (a != 0) begin
        inv = 8'h01;
        repeat (254) inv = gmul(inv, 8'(a));
      end
      m_sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {m_sb[tmp[31:24]], m_sb[tmp[23:16]], m_sb[tmp[15:8]], m_sb[tmp[7:0]]};
        tmp = tmp ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r <= 10; r++) m_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0;
      m_round <= 0;
      m_have  <= 1'b0;
    end else if (load) begin
      model_expand(inkey);
      m_have  <= 1'b1;
      m_round <= 0;
      m_phase <= 1;
    end else if (m_phase == 1) begin
      m_round <= m_round + 1;
      if (m_round == 9) m_phase <= 2;
    end else if (m_phase == 2 && step && m_round > 0) begin
      m_round <= m_round - 1;
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc busy", 128'(busy), 128'(m_phase == 1));
      chk("cyc keyvalid", 128'(keyvalid), 128'(m_phase == 2));
      chk("cyc round", 128'(round), 128'(m_round));
      chk("cyc outkey", outkey, m_have ? m_rk[m_round] : 128'h0);
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [127:0] k);
    load  = 1'b1;
    inkey = k;
    wait_cycles(1);
    load  = 1'b0;
  endtask

  task automatic do_step();
    step = 1'b1;
    wait_cycles(1);
    step = 1'b0;
  endtask

  localparam logic [127:0] FipsKey = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FipsR10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] FipsR9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] FipsR1  = 128'ha0fafe1788542cb123a339392a6c7605;

  initial begin
    logic [127:0] key_a, key_b;
    build_sbox();
    wait_cycles(2);
    cmp_en = 1'b1;

    // Reset state
    chk("reset busy", 128'(busy), 128'h0);
    chk("reset keyvalid", 128'(keyvalid), 128'h0);
    chk("reset round", 128'(round), 128'h0);
    chk("reset outkey", outkey, 128'h0);
    rst = 1'b0;
    wait_cycles(1);

    // FIPS-197 key: busy for ten edges, then round 10
    do_load(FipsKey);
    chk("fips busy first", 128'(busy), 128'h1);
    wait_cycles(9);
    chk("fips busy last", 128'(busy), 128'h1);
    chk("fips not valid yet", 128'(keyvalid), 128'h0);
    wait_cycles(1);
    chk("fips valid", 128'(keyvalid), 128'h1);
    chk("fips busy low", 128'(busy), 128'h0);
    chk("fips round10", 128'(round), 128'd10);
    chk("fips rk10", outkey, FipsR10);
    chk("model rk10", m_rk[10], FipsR10);
    do_step();
    chk("fips round9", 128'(round), 128'd9);
    chk("fips rk9", outkey, FipsR9);
    repeat (8) do_step();
    chk("fips round1", 128'(round), 128'd1);
    chk("fips rk1", outkey, FipsR1);
    chk("model rk1", m_rk[1], FipsR1);
    do_step();
    chk("fips round0", 128'(round), 128'd0);
    chk("fips rk0", outkey, FipsKey);
    do_step();
    do_step();
    chk("fips round0 hold", 128'(round), 128'd0);
    chk("fips rk0 hold", outkey, FipsKey);

    // Random keys with random step gaps, then step held high
    for (int n = 0; n < 4; n++) begin
      do_load({$urandom, $urandom, $urandom, $urandom});
      step = 1'($urandom_range(0, 1));  // ignored while expanding
      wait_cycles(10);
      for (int i = 0; i < 8; i++) begin
        step = 1'($urandom_range(0, 1));
        wait_cycles(1);
      end
      step = 1'b1;
      wait_cycles(11);
      step = 1'b0;
      chk("rand walk round0", 128'(round), 128'd0);
    end

    // Step held continuously walks one round per cycle
    key_a = {$urandom, $urandom, $urandom, $urandom};
    do_load(key_a);
    wait_cycles(10);
    step = 1'b1;
    for (int r = 9; r >= 0; r--) begin
      wait_cycles(1);
      chk("held step round", 128'(round), 128'(r));
    end
    step = 1'b0;
    chk("held step rk0", outkey, key_a);

    // Restart with a new key during expansion
    key_b = {$urandom, $urandom, $urandom, $urandom};
    do_load(key_a);
    wait_cycles(4);
    step = 1'b1;
    wait_cycles(1);
    chk("expand ignores step", 128'(round), 128'd5);
    load  = 1'b1;
    inkey = key_b;
    wait_cycles(1);
    load  = 1'b0;
    chk("restart round", 128'(round), 128'd0);
    chk("restart outkey", outkey, key_b);
    wait_cycles(2);
    step = 1'b0;
    wait_cycles(8);
    chk("restart valid", 128'(keyvalid), 128'h1);
    chk("restart rk10", outkey, m_rk[10]);

    // Load while READY drops keyvalid at the next edge
    do_load(FipsKey);
    chk("reload valid drop", 128'(keyvalid), 128'h0);
    wait_cycles(10);
    chk("reload rk10", outkey, FipsR10);

    // Reset mid-walk at round 4
    repeat (6) do_step();
    chk("pre-reset round", 128'(round), 128'd4);
    rst = 1'b1;
    #2;
    chk("async rst busy", 128'(busy), 128'h0);
    chk("async rst keyvalid", 128'(keyvalid), 128'h0);
    chk("async rst round", 128'(round), 128'h0);
    chk("async rst outkey", outkey, 128'h0);
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(1);
    do_load(FipsKey);
    wait_cycles(10);
    chk("post-reset round10", 128'(round), 128'd10);
    chk("post-reset rk10", outkey, FipsR10);
    wait_cycles(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inv_key_scheduler.md
Name: inv_key_scheduler

Overview:
Sequential AES-128 decryption-side key scheduler; the inverse counterpart of the forward round-key generator.
- Accepts the cipher key and expands forward internally to the last round key (round 10).
- Then walks the schedule backwards, one round key per step request, down to round 0.
- Feeds the inverse-cipher datapath, which consumes round keys in reverse order (10, 9, … 0).

Parameters:
- NR, 10, number of AES rounds; fixed at 10 for AES-128. Other values are unsupported; elaboration fails for NR != 10.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- load  input  1  pulse: capture inkey and start forward expansion.
- inkey  input  128  cipher key; word w0 = [127:96] … w3 = [31:0].
- step  input  1  request the previous round key; honoured only when keyvalid=1 and round>0.
- busy  output  1  high while forward expansion is in progress.
- keyvalid  output  1  high when outkey holds a valid round key.
- round  output  4  round index of outkey (10 down to 0).
- outkey  output  128  current round key, word order as inkey.

Behaviour:
- Reset (async assert, sync release): state=IDLE, key register=0, round=0, busy=0, keyvalid=0, outkey=0.
- State machine:
  - IDLE: load → capture inkey, round=0 → EXPAND.
  - EXPAND: each edge applies the forward step with Rcon(round) and increments round. When round reaches 10 → READY. busy=1 throughout EXPAND.
  - READY: keyvalid=1, busy=0. Each step with round>0 applies the inverse step with Rcon(round-1), then decrements round. step with round==0 is ignored; state stays READY at round 0.
- Forward step (round key r → r+1):
  - t = SubWord(RotWord(w3)) ^ Rcon(r), where RotWord moves the top byte to the bottom.
  - n0 = w0^t, n1 = n0^w1, n2 = n1^w2, n3 = n2^w3.
- Inverse step (round key r → r-1):
  - p3 = k3^k2, p2 = k2^k1, p1 = k1^k0.
  - p0 = k0 ^ SubWord(RotWord(p3)) ^ Rcon(r-1).
- Rcon(i) for i=0..9 is {01,02,04,08,10,20,40,80,1b,36} in the top byte, zero in the lower three bytes; any other index gives 0.
- Latency:
  - load sampled at edge E0.
  - busy visible from E0 to E10.
  - keyvalid=1 and round=10 after edge E10.
  - Each honoured step updates outkey and round at the next edge.
  - 10 steps return round 0, where outkey equals the original inkey.
- outkey always reflects the key register; the consumer must qualify it with keyvalid.
- Simultaneous events:
  - load has priority over step in every state.
  - load during EXPAND or READY restarts: new key, round=0, keyvalid drops next edge.
  - step during IDLE or EXPAND is ignored.
- Reset mid-EXPAND or mid-walk returns to IDLE immediately. No partial key is retained.

Decomposition:
- Shared package holds: NR, the Rcon lookup as a function indexed 0..9, and the state encoding (IDLE, EXPAND, READY).
- Sub-module sub_word:
  - 32-bit SubWord built from four existing sbox instances.
  - Instantiated once; its input is muxed between RotWord(w3) in EXPAND and RotWord(k3^k2) in READY.
  - This minimises S-box area.

Test Plan:
- FIPS-197 key: load inkey=2b7e151628aed2a6abf7158809cf4f3c → busy for 10 cycles; then keyvalid=1, round=10, outkey=d014f9a8c9ee2589e13f0cc8b6630ca6.
- One step from round 10 → round=9, outkey=ac7766f319fadc2128d12941575c006e. Continue to round 1 → outkey=a0fafe1788542cb123a339392a6c7605.
- Step again to round 0 → outkey=2b7e151628aed2a6abf7158809cf4f3c. Further steps → round stays 0, outkey unchanged.
- Random keys: compare each of the 11 outkeys against a software key-expansion model. Also check step held high continuously walks one round per cycle.
- load with a new key during EXPAND at round 5 → round restarts at 0. Round 10 key matches the new key's expansion; step pulses during EXPAND have no effect.
- Assert rst mid-walk at round 4 → busy=0, keyvalid=0, outkey=0, round=0 immediately (before the next edge). After release, a fresh load behaves as in the first scenario.
